sync_fifo_lvl: RTL and testbench

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock FIFO, for buffering inside one clock domain. Adds the following over the basic full/empty FIFO:
- fill-level output
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- selectable read mode: first-word-fall-through or registered read.

Sits between producer/consumer engines (bus bridges, UART/SPI datapaths) in a single clock domain.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram.sv | 44 ++++
 rtl/sync_fifo_lvl.sv | 137 +++++++++++++
 tb/tb_sync_fifo_lvl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO status type and depth helper
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port array, sync write, comb or registered read
module fifo_ram #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 32,
    parameter int REGOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [0:(1<<AWIDTH)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (REGOUT != 0) begin : g_reg
            logic [DWIDTH-1:0] rdata_q;
            // Captures the old head even when the same slot is rewritten this edge.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end else begin : g_comb
            logic unused_ok;
            assign unused_ok = ^{rst_i, re_i};
            assign rdata_o   = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - single-clock FIFO with level, thresholds, sticky errors, flush
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 32,
    parameter int FWFT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush,
    input  logic              write,
    input  logic              read,
    input  logic [DWIDTH-1:0] in,
    input  logic [AWIDTH:0]   afull_thresh,
    input  logic [AWIDTH:0]   aempty_thresh,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] out,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int PW    = fifo_clog2(DEPTH);
    localparam int LW    = AWIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              ov_q, ov_d;
    logic              wr_ok, rd_ok, mem_we, mem_re;
    logic [DWIDTH-1:0] ram_rdata;
    fifo_status_t      status;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ov_d     = 1'b0;
        rd_ok    = read && !empty_q;
        // A read on a full FIFO frees the slot this write lands in.
        wr_ok    = write && (!full_q || read);
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            mem_we = wr_ok;
            mem_re = rd_ok;
            ov_d   = rd_ok;
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_ok && !rd_ok) level_d = level_q + LW'(1);
            if (rd_ok && !wr_ok) level_d = level_q - LW'(1);
            // A new error event outranks a same-cycle clear.
            if (write && !wr_ok)  ovf_d = 1'b1;
            else if (err_clr)     ovf_d = 1'b0;
            if (read && !rd_ok)   unf_d = 1'b1;
            else if (err_clr)     unf_d = 1'b0;
        end
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ov_q     <= ov_d;
        end
    end

    fifo_ram #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH),
        .REGOUT ((FWFT == 0) ? 1 : 0)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (in),
        .re_i    (mem_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign status = '{
        full:         full_q,
        empty:        empty_q,
        almost_full:  (level_q >= afull_thresh),
        almost_empty: (level_q <= aempty_thresh),
        overflow:     ovf_q,
        underflow:    unf_q
    };

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign level        = level_q;

    // In FWFT mode the head is masked while empty so out reads as zero after reset/flush.
    assign out       = (FWFT != 0) ? (empty_q ? '0 : ram_rdata) : ram_rdata;
    assign out_valid = (FWFT != 0) ? !empty_q : ov_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb/tb_sync_fifo_lvl.sv - randomized and directed checks of both read modes against a queue model
module tb_sync_fifo_lvl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, fl, wr, rd, ec;
    logic [DW-1:0] di;
    logic [AW:0]   at, ae;

    logic [DW-1:0] out1, out0;
    logic          ov1, ov0, full1, full0, empty1, empty0, af1, af0, ae1, ae0;
    logic          ovf1, ovf0, unf1, unf0;
    logic [AW:0]   lvl1, lvl0;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf, m_ov0;
    logic [DW-1:0] m_out0;

    always #5 clk = ~clk;

    sync_fifo_lvl #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush(fl), .write(wr), .read(rd), .in(di),
        .afull_thresh(at), .aempty_thresh(ae), .err_clr(ec),
        .out(out1), .out_valid(ov1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .level(lvl1),
        .overflow(ovf1), .underflow(unf1));

    sync_fifo_lvl #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush(fl), .write(wr), .read(rd), .in(di),
        .afull_thresh(at), .aempty_thresh(ae), .err_clr(ec),
        .out(out0), .out_valid(ov0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .level(lvl0),
        .overflow(ovf0), .underflow(unf0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("level1", 64'(lvl1), 64'(n));
        chk("level0", 64'(lvl0), 64'(n));
        chk("full1", 64'(full1), 64'(n == DEPTH));
        chk("full0", 64'(full0), 64'(n == DEPTH));
        chk("empty1", 64'(empty1), 64'(n == 0));
        chk("empty0", 64'(empty0), 64'(n == 0));
        chk("afull1", 64'(af1), 64'(n >= int'(at)));
        chk("afull0", 64'(af0), 64'(n >= int'(at)));
        chk("aempty1", 64'(ae1), 64'(n <= int'(ae)));
        chk("aempty0", 64'(ae0), 64'(n <= int'(ae)));
        chk("ovf1", 64'(ovf1), 64'(m_ovf));
        chk("ovf0", 64'(ovf0), 64'(m_ovf));
        chk("unf1", 64'(unf1), 64'(m_unf));
        chk("unf0", 64'(unf0), 64'(m_unf));
        chk("out_fwft", 64'(out1), (n == 0) ? 64'd0 : 64'(mq[0]));
        chk("ovalid_fwft", 64'(ov1), 64'(n != 0));
        chk("out_reg", 64'(out0), 64'(m_out0));
        chk("ovalid_reg", 64'(ov0), 64'(m_ov0));
    endtask

    // Drive one cycle, advance the model by the same inputs, then compare.
    task automatic step(input logic r_s, input logic f_s, input logic w_s, input logic rd_s,
                        input logic [DW-1:0] d_s, input logic ec_s);
        logic rdok, wrok;
        rst = r_s; fl = f_s; wr = w_s; rd = rd_s; di = d_s; ec = ec_s;
        @(posedge clk);
        if (r_s) begin
            mq.delete(); m_ovf = 0; m_unf = 0; m_ov0 = 0; m_out0 = '0;
        end else if (f_s) begin
            mq.delete(); m_ovf = 0; m_unf = 0; m_ov0 = 0;
        end else begin
            rdok = rd_s && (mq.size() > 0);
            wrok = w_s && ((mq.size() < DEPTH) || rd_s);
            m_ov0 = rdok;
            if (rdok) m_out0 = mq.pop_front();
            if (wrok) mq.push_back(d_s);
            m_ovf = (w_s && !wrok) ? 1'b1 : (ec_s ? 1'b0 : m_ovf);
            m_unf = (rd_s && !rdok) ? 1'b1 : (ec_s ? 1'b0 : m_unf);
        end
        #1;
        check_all();
    endtask

    initial begin
        int writes, iter;
        m_ovf = 0; m_unf = 0; m_ov0 = 0; m_out0 = '0;
        rst = 1; fl = 0; wr = 0; rd = 0; di = '0; ec = 0;
        at = '0; ae = 5'd3;

        // Reset values, including almost_full with a zero threshold.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 32'hDEAD, 0);
        at = 5'd16;
        #1;
        check_all();

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 32'(i), 0);
        step(0, 0, 1, 0, 32'hEE, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Full FIFO with simultaneous read and write keeps level at DEPTH.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 32'(i), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 32'hA0 + 32'(i), 0);

        // Empty FIFO: read rejected but write lands; then clear the flag.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h1234_5678, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);

        // Thresholds, including a live change of afull_thresh.
        at = 5'd12; ae = 5'd3;
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) step(0, 0, 1, 0, $urandom, 0);
        at = 5'd20;
        #1;
        check_all();
        ae = 5'd16;
        #1;
        check_all();
        at = 5'd12; ae = 5'd3;

        // Wrap-around: 40 writes with random gaps, level capped at 10.
        step(0, 1, 0, 0, 0, 0);
        writes = 0;
        iter = 0;
        while ((writes < 40 || mq.size() > 0) && iter < 600) begin
            logic w_s, r_s;
            w_s = (writes < 40) && (mq.size() < 10) && ($urandom_range(0, 2) != 0);
            r_s = ($urandom_range(0, 2) == 0) && (mq.size() > 0);
            if (w_s) writes++;
            step(0, 0, w_s, r_s, $urandom, 0);
            iter++;
        end
        chk("wrap_budget", 64'(iter < 600), 64'd1);

        // Fully random traffic, occasional clears and flushes.
        for (int i = 0; i < 400; i++) begin
            at = 5'($urandom_range(0, 18));
            ae = 5'($urandom_range(0, 17));
            step(0, ($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 10) == 0));
        end

        // Registered read mode: one-cycle valid, flush holds out but drops valid.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 32'h55, 0);
        step(0, 0, 1, 0, 32'h66, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("reg_out_55", 64'(out0), 64'h55);
        chk("reg_valid_pulse", 64'(ov0), 64'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("reg_valid_drop", 64'(ov0), 64'd0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 32'h77, 0);
        step(0, 1, 1, 1, 32'h88, 0);
        chk("flush_out_hold", 64'(out0), 64'h66);
        step(0, 0, 1, 0, 32'h99, 0);
        step(1, 1, 1, 1, 32'hAA, 1);
        chk("rst_out0", 64'(out0), 64'd0);
        step(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
